// File: rtl/pixel_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pixel_fetch_pkg
// Shared types for the pixel fetch responder:
//   fetch_state_e  - read-master FSM states
//   cache_entry_t  - one cached frame-buffer word {valid, tag, data}
//   BYTES_PER_WORD - pixels packed per 32-bit frame-buffer word
//   lane_byte()    - selects one pixel byte from a packed word
// -----------------------------------------------------------------------------
package pixel_fetch_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DATA,
      PF_ISSUE,
      PF_WAIT
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] data;
   } cache_entry_t;

   // Byte lane k of the word holds the pixel whose column satisfies x%4 == k.
   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/pixel_fetch_responder_addr_gen.sv
// -----------------------------------------------------------------------------
// pixel_addr_gen
// Maps a pixel coordinate to its frame-buffer location.
//   x_i, y_i    - requested column / row
//   in_range_o  - 1 when the coordinate lies inside the ROW_NUM x COL_NUM frame
//   tag_o       - word address (byte address [31:2]) holding the pixel
//   lane_o      - byte lane of the pixel inside that word
// -----------------------------------------------------------------------------
module pixel_addr_gen #(
   parameter int unsigned ROW_NUM   = 480,
   parameter int unsigned COL_NUM   = 640,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic [10:0] x_i,
   input  logic [10:0] y_i,
   output logic        in_range_o,
   output logic [29:0] tag_o,
   output logic [1:0]  lane_o
);

   logic [31:0] addr;

   assign in_range_o = ({21'd0, x_i} < COL_NUM) && ({21'd0, y_i} < ROW_NUM);
   assign addr       = BASE_ADDR + ({21'd0, y_i} * COL_NUM) + {21'd0, x_i};
   assign tag_o      = addr[31:2];
   // BASE_ADDR is word aligned and COL_NUM a multiple of 4, so addr[1:0] == x[1:0].
   assign lane_o     = addr[1:0];

endmodule

// File: rtl/pixel_fetch_responder.sv
// -----------------------------------------------------------------------------
// pixel_fetch_responder
// Serves 8-bit pixels to the edge-detection core from a packed frame buffer
// behind an Avalon-MM read master. A one-word main entry gives zero-wait hits;
// a one-word prefetch entry, refilled with the next sequential word, keeps a
// row-order scan running at one pixel per cycle.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   en                   - responder enable (outputs forced to 0 when low)
//   flush                - frame-start pulse, invalidates both entries
//   next_pixel_x/_y      - requested coordinate
//   pixel, waitrequest   - response to the core (pixel valid when waitrequest=0)
//   avm_*                - Avalon-MM read master, one read outstanding at most
// -----------------------------------------------------------------------------
module pixel_fetch_responder
   import pixel_fetch_pkg::*;
#(
   parameter int unsigned ROW_NUM   = 480,
   parameter int unsigned COL_NUM   = 640,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned PREFETCH  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        flush,
   input  logic [10:0] next_pixel_x,
   input  logic [10:0] next_pixel_y,
   output logic [7:0]  pixel,
   output logic        waitrequest,
   output logic [31:0] avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid
);

   localparam logic [31:0] LAST_WORD_ADDR = BASE_ADDR + (ROW_NUM * COL_NUM) - BYTES_PER_WORD;
   localparam logic [29:0] LAST_TAG       = LAST_WORD_ADDR[31:2];

   logic         in_range;
   logic [29:0]  req_tag;
   logic [1:0]   req_lane;

   fetch_state_e state_q, state_d;
   cache_entry_t main_q, main_d;
   cache_entry_t pf_q, pf_d;
   logic [29:0]  rd_tag_q, rd_tag_d;     // word address of the read in flight
   logic         discard_q, discard_d;   // in-flight data must not be filled

   logic active, main_hit, pf_hit, miss, drop;

   pixel_addr_gen #(
      .ROW_NUM   (ROW_NUM),
      .COL_NUM   (COL_NUM),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr_gen (
      .x_i        (next_pixel_x),
      .y_i        (next_pixel_y),
      .in_range_o (in_range),
      .tag_o      (req_tag),
      .lane_o     (req_lane)
   );

   // A flush cycle already treats both entries as invalid.
   assign active   = en && !rst && in_range;
   assign main_hit = active && !flush && main_q.valid && (main_q.tag == req_tag);
   assign pf_hit   = active && !flush && !main_hit && pf_q.valid && (pf_q.tag == req_tag);
   assign miss     = active && !main_hit && !pf_hit;
   assign drop     = discard_q || flush || !en;

   assign avm_read    = (state_q == ISSUE) || (state_q == PF_ISSUE);
   assign avm_address = {rd_tag_q, 2'b00};

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      main_d      = main_q;
      pf_d        = pf_q;
      rd_tag_d    = rd_tag_q;
      discard_d   = discard_q;
      pixel       = 8'd0;
      waitrequest = 1'b0;

      if (main_hit) begin
         pixel = lane_byte(main_q.data, req_lane);
      end else if (pf_hit) begin
         pixel      = lane_byte(pf_q.data, req_lane);
         main_d     = pf_q;
         pf_d.valid = 1'b0;
      end else if (miss) begin
         waitrequest = 1'b1;
      end

      // Data of a read already on the bus is still consumed, just not kept.
      if ((flush || !en) && (state_q != IDLE)) begin
         discard_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (pf_hit) begin
               if ((PREFETCH != 0) && (pf_q.tag < LAST_TAG)) begin
                  state_d  = PF_ISSUE;
                  rd_tag_d = pf_q.tag + 30'd1;
               end
            end else if (miss) begin
               state_d  = ISSUE;
               rd_tag_d = req_tag;
            end
         end
         ISSUE: begin
            if (!avm_waitrequest) state_d = WAIT_DATA;
         end
         PF_ISSUE: begin
            if (!avm_waitrequest) state_d = PF_WAIT;
         end
         WAIT_DATA, PF_WAIT: begin
            if (avm_readdatavalid) begin
               state_d   = IDLE;
               discard_d = 1'b0;
               if (!drop) begin
                  if (state_q == WAIT_DATA) begin
                     main_d = '{valid: 1'b1, tag: rd_tag_q, data: avm_readdata};
                     if ((PREFETCH != 0) && (rd_tag_q < LAST_TAG)) begin
                        state_d  = PF_ISSUE;
                        rd_tag_d = rd_tag_q + 30'd1;
                     end
                  end else begin
                     pf_d = '{valid: 1'b1, tag: rd_tag_q, data: avm_readdata};
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Flush wins over any fill or promotion in the same cycle.
      if (flush) begin
         main_d.valid = 1'b0;
         pf_d.valid   = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values. Only the valid bits of the cache entries are reset;
   // tag and data are meaningless while valid is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rd_tag_q     <= '0;
         discard_q    <= 1'b0;
         main_q.valid <= 1'b0;
         pf_q.valid   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_tag_q  <= rd_tag_d;
         discard_q <= discard_d;
         main_q    <= main_d;
         pf_q      <= pf_d;
      end
   end

endmodule

// File: tb/tb_pixel_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_pixel_fetch_responder
// Self-checking bench: a behavioural Avalon slave backed by a frame-buffer
// model, directed scenarios for cold fetch, padding, addressing, stall,
// prefetch, flush, reset and enable, then a randomized request stream whose
// pixels are checked against the frame model.
// -----------------------------------------------------------------------------
module tb_pixel_fetch_responder;

   localparam int          ROWS = 480;
   localparam int          COLS = 640;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst, en, flush;
   logic [10:0] px, py;
   logic [7:0]  pixel;
   logic        waitrequest;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   always #5 clk = ~clk;

   pixel_fetch_responder #(
      .ROW_NUM   (ROWS),
      .COL_NUM   (COLS),
      .BASE_ADDR (BASE),
      .PREFETCH  (1)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .en                (en),
      .flush             (flush),
      .next_pixel_x      (px),
      .next_pixel_y      (py),
      .pixel             (pixel),
      .waitrequest       (waitrequest),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Frame-buffer contents: two fixed words for the directed cases, a hash elsewhere.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'h4433_2211;
      if (a == 32'h0000_1504) return 32'hDDCC_BBAA;
      return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
   endfunction

   function automatic logic [31:0] byte_addr(input int x, input int y);
      return BASE + 32'(y) * 32'(COLS) + 32'(x);
   endfunction

   function automatic logic [7:0] exp_pixel(input int x, input int y);
      logic [31:0] a, w;
      if (x >= COLS || y >= ROWS) return 8'd0;
      a = byte_addr(x, y);
      w = word_of({a[31:2], 2'b00});
      return 8'(w >> (8 * a[1:0]));
   endfunction

   // ---------------- behavioural Avalon slave ----------------
   int          cyc = 0;
   int          stall_cfg = 0;      // one-shot: stalls applied to the next read
   int          lat_cfg = 3;        // cycles from acceptance to readdatavalid
   int          rd_count = 0;
   int          stall_edges = 0;
   int          last_rdv_cyc = -1;
   int          last_serve_cyc = -1;
   int          sl_state = 0;       // 0 idle, 1 stalling, 2 awaiting data
   int          stall_left = 0;
   int          lat_left = 0;
   logic [31:0] sl_addr = '0;
   logic [31:0] rd_log[$];

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      forever begin
         @(posedge clk);
         #1;
         avm_readdatavalid = 1'b0;
         if (rst) begin
            sl_state        = 0;
            avm_waitrequest = 1'b0;
         end else begin
            case (sl_state)
               0: if (avm_read) begin
                     sl_addr = avm_address;
                     rd_log.push_back(avm_address);
                     rd_count++;
                     check("read addr aligned in frame",
                           32'(sl_addr[1:0] == 2'b00 && sl_addr >= BASE && sl_addr < BASE + ROWS * COLS), 32'd1);
                     if (stall_cfg > 0) begin
                        avm_waitrequest = 1'b1;
                        stall_edges++;
                        stall_left = stall_cfg - 1;
                        stall_cfg  = 0;
                        sl_state   = 1;
                     end else begin
                        avm_waitrequest = 1'b0;
                        lat_left = lat_cfg;
                        sl_state = 2;
                     end
                  end
               1: begin
                     check("read held in stall", 32'(avm_read), 32'd1);
                     check("addr held in stall", avm_address, sl_addr);
                     if (stall_left > 0) begin
                        stall_left--;
                        stall_edges++;
                     end else begin
                        avm_waitrequest = 1'b0;
                        lat_left = lat_cfg;
                        sl_state = 2;
                     end
                  end
               default: begin
                     check("single outstanding", 32'(avm_read), 32'd0);
                     lat_left--;
                     if (lat_left <= 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = word_of(sl_addr);
                        last_rdv_cyc      = cyc;
                        sl_state          = 0;
                     end
                  end
            endcase
         end
      end
   end

   // ---------------- requester helpers ----------------
   task automatic serve(input int x, input int y, input string tag, output int waited);
      px = 11'(x);
      py = 11'(y);
      waited = 0;
      @(negedge clk);
      while (waitrequest === 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      last_serve_cyc = cyc;
      check({tag, " served"}, 32'(waitrequest), 32'd0);
      check({tag, " pixel"}, 32'(pixel), 32'(exp_pixel(x, y)));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int quiet = 0;
      int n = 0;
      while (quiet < 3 && n < 200) begin
         @(posedge clk);
         #2;
         if (sl_state == 0 && !avm_read && !avm_readdatavalid) quiet++;
         else quiet = 0;
         n++;
      end
      check("bus idle", 32'(quiet >= 3), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accepted(input string tag);
      int n = 0;
      while (sl_state != 2 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      check(tag, 32'(sl_state), 32'd2);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, n0, tot, cx, cy, ox, oy, r, n;

      rst = 1'b1; en = 1'b1; flush = 1'b0; px = 11'd0; py = 11'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset waitrequest", 32'(waitrequest), 32'd0);
      check("reset pixel", 32'(pixel), 32'd0);
      check("reset avm_read", 32'(avm_read), 32'd0);
      check("reset avm_address", avm_address, 32'd0);
      px = 11'd640;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Cold fetch of (0,0).
      lat_cfg = 3; stall_cfg = 0; n0 = rd_count;
      px = 11'd0; py = 11'd0;
      @(negedge clk);
      check("cold miss waitrequest", 32'(waitrequest), 32'd1);
      @(posedge clk); #1;
      check("cold read strobe", 32'(avm_read), 32'd1);
      check("cold read addr", avm_address, 32'h0000_1000);
      serve(0, 0, "cold", w);
      check("cold pixel value", 32'(pixel), 32'h11);
      check("cold served after rdv", 32'(last_serve_cyc), 32'(last_rdv_cyc + 1));
      serve(1, 0, "hit x1", w);
      check("hit x1 zero wait", 32'(w), 32'd0);
      serve(3, 0, "hit x3", w);
      check("hit x3 zero wait", 32'(w), 32'd0);
      check("hit x3 value", 32'(pixel), 32'h44);

      // Prefetch of the following word, then promotion.
      wait_idle();
      check("prefetch issued", 32'(rd_log.size() > n0 + 1), 32'd1);
      if (rd_log.size() > n0 + 1) check("prefetch addr", rd_log[n0 + 1], 32'h0000_1004);
      serve(4, 0, "pf hit", w);
      check("pf hit zero wait", 32'(w), 32'd0);
      check("next prefetch strobe", 32'(avm_read), 32'd1);
      check("next prefetch addr", avm_address, 32'h0000_1008);
      wait_idle();

      // Padding column and row.
      n0 = rd_count;
      serve(640, 0, "pad col", w);
      check("pad col zero wait", 32'(w), 32'd0);
      serve(0, 480, "pad row", w);
      check("pad row zero wait", 32'(w), 32'd0);
      serve(2047, 2047, "pad max", w);
      check("pad max zero wait", 32'(w), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("pad no reads", 32'(rd_count), 32'(n0));

      // Row addressing.
      n0 = rd_count;
      serve(5, 2, "row", w);
      check("row pixel value", 32'(pixel), 32'hBB);
      if (rd_log.size() > n0) check("row read addr", rd_log[n0], 32'h0000_1504);
      else check("row read issued", 32'(rd_log.size()), 32'(n0 + 1));
      wait_idle();

      // Interconnect stall of five cycles.
      stall_edges = 0; stall_cfg = 5;
      serve(100, 3, "stall", w);
      check("stall edge count", 32'(stall_edges), 32'd5);
      wait_idle();

      // Flush while waiting for data: refetch of the same word.
      lat_cfg = 6; n0 = rd_count;
      px = 11'd8; py = 11'd5;
      wait_accepted("flush read accepted");
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      serve(8, 5, "flush refetch", w);
      check("flush two reads", 32'(rd_log.size() >= n0 + 2), 32'd1);
      if (rd_log.size() >= n0 + 2) begin
         check("flush first addr", rd_log[n0], byte_addr(8, 5) & ~32'd3);
         check("flush refetch addr", rd_log[n0 + 1], byte_addr(8, 5) & ~32'd3);
      end
      wait_idle();

      // Reset while the read is stalled in ISSUE.
      lat_cfg = 3; stall_cfg = 10;
      px = 11'd20; py = 11'd7;
      n = 0;
      while (!avm_read && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      check("rst test read started", 32'(avm_read), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst avm_read", 32'(avm_read), 32'd0);
      check("rst waitrequest", 32'(waitrequest), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      stall_cfg = 0;
      serve(20, 7, "after rst", w);
      wait_idle();

      // Enable low: quiet outputs and no reads.
      n0 = rd_count;
      en = 1'b0; px = 11'd30; py = 11'd9;
      @(negedge clk);
      check("en0 waitrequest", 32'(waitrequest), 32'd0);
      check("en0 pixel", 32'(pixel), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("en0 no reads", 32'(rd_count), 32'(n0));

      // Enable dropped mid-read: data discarded, word refetched later.
      lat_cfg = 5;
      en = 1'b1;
      wait_accepted("en read accepted");
      en = 1'b0;
      @(negedge clk);
      check("en drop waitrequest", 32'(waitrequest), 32'd0);
      check("en drop pixel", 32'(pixel), 32'd0);
      wait_idle();
      en = 1'b1;
      serve(30, 9, "en refetch", w);
      if (rd_log.size() >= n0 + 2) check("en refetch same word", rd_log[n0 + 1], rd_log[n0]);
      else check("en refetch count", 32'(rd_log.size()), 32'(n0 + 2));

      // Row-order scan after a flush: one pixel per cycle once primed.
      px = 11'd2047; py = 11'd2047;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_idle();
      lat_cfg = 1; stall_cfg = 0; tot = 0;
      for (int x = 0; x < 64; x++) begin
         serve(x, 10, "scan", w);
         if (x >= 4) tot += w;
      end
      check("scan streaming waits", 32'(tot), 32'd0);
      wait_idle();

      // Randomized request stream.
      cx = 600; cy = 20;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         lat_cfg = int'($urandom_range(1, 4));
         if ($urandom_range(0, 3) == 0) stall_cfg = int'($urandom_range(1, 3));
         if (r < 4) begin
            px = 11'd2047; py = 11'd2047;
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
         end
         if (r < 70) begin
            cx++;
            if (cx >= COLS) begin
               cx = 0;
               cy = (cy + 1) % ROWS;
            end
            serve(cx, cy, "rand seq", w);
         end else if (r < 90) begin
            cx = int'($urandom_range(0, COLS - 1));
            cy = int'($urandom_range(0, ROWS - 1));
            serve(cx, cy, "rand jump", w);
         end else begin
            if ($urandom_range(0, 1) == 1) begin
               ox = int'($urandom_range(COLS, 2047));
               oy = int'($urandom_range(0, 2047));
            end else begin
               ox = int'($urandom_range(0, 2047));
               oy = int'($urandom_range(ROWS, 2047));
            end
            serve(ox, oy, "rand pad", w);
            check("rand pad zero wait", 32'(w), 32'd0);
         end
      end
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
